riscv_alu_ctrl_decode_pipe: RTL and testbench
=============================================

Name: riscv_alu_ctrl_decode_pipe

Overview:
Registered, handshaked successor to the combinational ALU control decoder. It decodes opcode/funct3/funct7 into ALU operand-source selects and an ALU operation for the full RV32I base set, with optional RV32M. It sits between the instruction-decode stage and the execute stage as one pipeline register with valid/ready flow control. It also enforces issue stalls for multi-cycle MUL/DIV operations and flags illegal encodings.

Parameters:
ALU_OP_WIDTH, 5, width of alu_op (≥5); encodings zero-extended
ENABLE_M, 1, 1 = decode RV32M (funct7=7'h01 on OPER_REG); 0 = those encodings are illegal
MUL_LATENCY, 3, execute cycles for the MUL class (≥1)
DIV_LATENCY, 34, execute cycles for the DIV/REM class (≥1)
CNT_WIDTH, 6, busy counter width; must hold max(MUL_LATENCY,DIV_LATENCY)-1

Ports:
clk  in  1  clock
rst  in  1  reset (synchronous, active-high)
flush  in  1  drop the held instruction and clear the stall
in_valid  in  1  decode fields valid
in_ready  out  1  block can accept
opcode  in  7  instr[6:0]
funct3  in  3  instr[14:12]
funct7  in  7  instr[31:25]
out_valid  out  1  decoded control valid
out_ready  in  1  execute accepts
alu_x_src  out  2  0=REG 1=PC 2=ZERO
alu_y_src  out  2  0=REG 1=IMM 2=SHAMT 3=FOUR
alu_op  out  ALU_OP_WIDTH  operation code
is_muldiv  out  1  alu_op is an M-class op
illegal  out  1  encoding illegal
busy  out  1  multi-cycle stall active

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: out_valid=0, alu_x_src=0, alu_y_src=0, alu_op=31 (INVALID), is_muldiv=0, illegal=0, busy counter=0.
- alu_op codes:
  - Base: ADD0 SUB1 SLL2 SLT3 SLTU4 XOR5 SRL6 SRA7 OR8 AND9.
  - M class: MUL16 MULH17 MULHSU18 MULHU19 DIV20 DIVU21 REM22 REMU23.
  - INVALID31.
- Decode by opcode:
  - LUI 0x37: ZERO, IMM, ADD.
  - AUIPC 0x17: PC, IMM, ADD.
  - JAL 0x6F and JALR 0x67: PC, FOUR, ADD.
  - BRANCH 0x63: REG, REG, SUB.
  - LOAD 0x03 and STORE 0x23: REG, IMM, ADD.
  - OPER_IMM 0x13: x=REG; y=SHAMT when funct3 is 001 or 101, else IMM. Ops per funct3 as for register ops.
    - funct3=101: funct7 0x00 gives SRL, 0x20 gives SRA.
    - funct3=001 with funct7≠0x00, or 101 with funct7 outside {0x00,0x20}: illegal.
  - OPER_REG 0x33: REG, REG.
    - funct7 0x00: base op.
    - funct7 0x20: valid only for funct3 000 (SUB) and 101 (SRA).
    - funct7 0x01 with ENABLE_M: op = 16+funct3.
    - Anything else: illegal.
  - FENCE 0x0F and SYSTEM 0x73: REG, REG, INVALID, illegal=0.
  - Any other opcode: illegal.
- Illegal entries output REG, REG, INVALID with illegal=1. They still traverse the handshake.
- Stall class of the held op:
  - MUL class: alu_op 16–19. DIV class: 20–23.
  - A class is multi-cycle only if its latency is >1.
- in_ready = !flush && busy_cnt==0 && (!out_valid || (out_ready && !held_multi)).
  - held_multi = the held op is a multi-cycle class.
  - Consequence: no back-to-back accept behind a multi-cycle op.
- Accept (in_valid && in_ready):
  - Outputs are registered; latency 1 cycle.
  - out_valid=1 on the following cycle.
- Output handshake (out_valid && out_ready) with no accept in the same cycle: out_valid←0.
- Holding: while out_valid && !out_ready, all outputs stay stable.
- Busy counter:
  - On an output handshake of a MUL-class op, load MUL_LATENCY-1. For a DIV-class op, load DIV_LATENCY-1.
  - Decrement each cycle while nonzero. busy = (busy_cnt≠0).
  - Net effect: after a DIV handshake at cycle T, the next accept occurs no earlier than cycle T+DIV_LATENCY.
- flush:
  - Next cycle: out_valid=0, busy_cnt=0.
  - An in_valid in a flush cycle is not accepted.
  - Other output registers keep their values.
- rst has priority over flush. flush has priority over accept and handshake.
- Reset in the middle of a stall returns the block to the reset state.

Test Plan:
- ADD then SUB: opcode 0x33/f3 0/f7 0x00 followed by f7 0x20, out_ready=1 → alu_op 0 then 1, x=0, y=0. One accept per cycle, latency 1.
- AUIPC and JAL: AUIPC 0x17 → x=1, y=1, op=0. JAL 0x6F → x=1, y=3, op=0. SRAI (0x13/101/0x20) → y=2, op=7.
- Backpressure: out_ready=0 for 4 cycles with the next input valid → in_ready=0, outputs stable. The second instruction emerges one cycle after out_ready rises.
- DIV stall: DIV_LATENCY=34, issue DIV (0x33/100/0x01) then ADD → op=20, is_muldiv=1. busy=1 for 33 cycles after the handshake. ADD is accepted 34 cycles after the DIV handshake.
- Illegal encodings: ENABLE_M=0 with f7 0x01 → illegal=1, op=31. opcode 0x7F → illegal=1. SLLI with f7 0x20 → illegal=1.
- Flush and reset mid-stall: flush 5 cycles into a DIV stall → busy=0 and out_valid=0 next cycle, in_ready=1. rst asserted while out_valid=1 → reset values on the next cycle.

Source files
------------

// File: rtl/riscv_alu_ctrl_decode_pipe.sv
// Purpose: RV32I(+M) ALU-control decoder held in one valid/ready pipeline register, with MUL/DIV issue stall.
// Latency: 1 cycle from accept to out_valid; decode outputs are registered.
// Backpressure: holds outputs while out_valid && !out_ready; in_ready drops while busy, on flush, or behind a held multi-cycle op.
// Ports: clk/rst (sync, active-high), flush; in_valid/in_ready + opcode/funct3/funct7 from decode;
//        out_valid/out_ready + alu_x_src/alu_y_src/alu_op/is_muldiv/illegal to execute; busy = stall counter nonzero.
module riscv_alu_ctrl_decode_pipe #(
  parameter int ALU_OP_WIDTH = 5,
  parameter int ENABLE_M     = 1,
  parameter int MUL_LATENCY  = 3,
  parameter int DIV_LATENCY  = 34,
  parameter int CNT_WIDTH    = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [6:0]              opcode,
  input  logic [2:0]              funct3,
  input  logic [6:0]              funct7,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [1:0]              alu_x_src,
  output logic [1:0]              alu_y_src,
  output logic [ALU_OP_WIDTH-1:0] alu_op,
  output logic                    is_muldiv,
  output logic                    illegal,
  output logic                    busy
);

  localparam logic [1:0] X_REG   = 2'd0;
  localparam logic [1:0] X_PC    = 2'd1;
  localparam logic [1:0] X_ZERO  = 2'd2;
  localparam logic [1:0] Y_REG   = 2'd0;
  localparam logic [1:0] Y_IMM   = 2'd1;
  localparam logic [1:0] Y_SHAMT = 2'd2;
  localparam logic [1:0] Y_FOUR  = 2'd3;

  localparam logic [4:0] OP_ADD     = 5'd0;
  localparam logic [4:0] OP_SUB     = 5'd1;
  localparam logic [4:0] OP_SLL     = 5'd2;
  localparam logic [4:0] OP_SLT     = 5'd3;
  localparam logic [4:0] OP_SLTU    = 5'd4;
  localparam logic [4:0] OP_XOR     = 5'd5;
  localparam logic [4:0] OP_SRL     = 5'd6;
  localparam logic [4:0] OP_SRA     = 5'd7;
  localparam logic [4:0] OP_OR      = 5'd8;
  localparam logic [4:0] OP_AND     = 5'd9;
  localparam logic [4:0] OP_INVALID = 5'd31;

  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_IMM    = 7'h13;
  localparam logic [6:0] OPC_REG    = 7'h33;
  localparam logic [6:0] OPC_FENCE  = 7'h0F;
  localparam logic [6:0] OPC_SYSTEM = 7'h73;

  // Only classes that actually take more than one cycle stall issue.
  localparam bit MUL_MULTI = (MUL_LATENCY > 1);
  localparam bit DIV_MULTI = (DIV_LATENCY > 1);

  logic                    r_out_valid;
  logic [1:0]              r_x_src;
  logic [1:0]              r_y_src;
  logic [ALU_OP_WIDTH-1:0] r_op;
  logic                    r_muldiv;
  logic                    r_illegal;
  logic [CNT_WIDTH-1:0]    r_busy_cnt;

  logic [1:0] w_x_src;
  logic [1:0] w_y_src;
  logic [4:0] w_op;
  logic       w_illegal;
  logic       w_held_mul;
  logic       w_held_div;
  logic       w_held_multi;
  logic       w_accept;
  logic       w_handshake;
  logic       w_cnt_zero;

  // funct3 -> base op, ignoring the funct7 alternate (SUB/SRA) encodings.
  function automatic logic [4:0] base_op(input logic [2:0] f3);
    case (f3)
      3'b000:  base_op = OP_ADD;
      3'b001:  base_op = OP_SLL;
      3'b010:  base_op = OP_SLT;
      3'b011:  base_op = OP_SLTU;
      3'b100:  base_op = OP_XOR;
      3'b101:  base_op = OP_SRL;
      3'b110:  base_op = OP_OR;
      default: base_op = OP_AND;
    endcase
  endfunction

  always_comb begin
    w_x_src   = X_REG;
    w_y_src   = Y_REG;
    w_op      = OP_INVALID;
    w_illegal = 1'b0;
    case (opcode)
      OPC_LUI: begin
        w_x_src = X_ZERO;
        w_y_src = Y_IMM;
        w_op    = OP_ADD;
      end
      OPC_AUIPC: begin
        w_x_src = X_PC;
        w_y_src = Y_IMM;
        w_op    = OP_ADD;
      end
      OPC_JAL, OPC_JALR: begin
        w_x_src = X_PC;
        w_y_src = Y_FOUR;
        w_op    = OP_ADD;
      end
      OPC_BRANCH: begin
        w_op = OP_SUB;
      end
      OPC_LOAD, OPC_STORE: begin
        w_y_src = Y_IMM;
        w_op    = OP_ADD;
      end
      OPC_IMM: begin
        // funct7 only carries meaning for the shift-immediate forms.
        w_y_src = (funct3 == 3'b001 || funct3 == 3'b101) ? Y_SHAMT : Y_IMM;
        w_op    = base_op(funct3);
        if (funct3 == 3'b001 && funct7 != 7'h00) begin
          w_illegal = 1'b1;
        end else if (funct3 == 3'b101) begin
          if (funct7 == 7'h20) begin
            w_op = OP_SRA;
          end else if (funct7 != 7'h00) begin
            w_illegal = 1'b1;
          end
        end
      end
      OPC_REG: begin
        if (funct7 == 7'h00) begin
          w_op = base_op(funct3);
        end else if (funct7 == 7'h20 && funct3 == 3'b000) begin
          w_op = OP_SUB;
        end else if (funct7 == 7'h20 && funct3 == 3'b101) begin
          w_op = OP_SRA;
        end else if (funct7 == 7'h01 && ENABLE_M != 0) begin
          w_op = {2'b10, funct3};
        end else begin
          w_illegal = 1'b1;
        end
      end
      OPC_FENCE, OPC_SYSTEM: begin
        // No ALU work; defaults (REG, REG, INVALID) with illegal clear.
      end
      default: begin
        w_illegal = 1'b1;
      end
    endcase
    if (w_illegal) begin
      w_x_src = X_REG;
      w_y_src = Y_REG;
      w_op    = OP_INVALID;
    end
  end

  assign w_held_mul   = (r_op >= ALU_OP_WIDTH'(16)) && (r_op <= ALU_OP_WIDTH'(19));
  assign w_held_div   = (r_op >= ALU_OP_WIDTH'(20)) && (r_op <= ALU_OP_WIDTH'(23));
  assign w_held_multi = (w_held_mul && MUL_MULTI) || (w_held_div && DIV_MULTI);
  assign w_cnt_zero   = (r_busy_cnt == '0);

  // A held multi-cycle op blocks same-cycle refill so the stall counter
  // starts before anything else can issue behind it.
  assign in_ready    = !flush && w_cnt_zero && (!r_out_valid || (out_ready && !w_held_multi));
  assign w_accept    = in_valid && in_ready;
  assign w_handshake = r_out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_x_src     <= X_REG;
      r_y_src     <= Y_REG;
      r_op        <= ALU_OP_WIDTH'(OP_INVALID);
      r_muldiv    <= 1'b0;
      r_illegal   <= 1'b0;
      r_busy_cnt  <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
      r_busy_cnt  <= '0;
    end else begin
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_x_src     <= w_x_src;
        r_y_src     <= w_y_src;
        r_op        <= ALU_OP_WIDTH'(w_op);
        r_muldiv    <= (w_op[4:3] == 2'b10);
        r_illegal   <= w_illegal;
      end else if (w_handshake) begin
        r_out_valid <= 1'b0;
      end

      if (w_handshake && w_held_mul) begin
        r_busy_cnt <= CNT_WIDTH'(MUL_LATENCY - 1);
      end else if (w_handshake && w_held_div) begin
        r_busy_cnt <= CNT_WIDTH'(DIV_LATENCY - 1);
      end else if (!w_cnt_zero) begin
        r_busy_cnt <= r_busy_cnt - 1'b1;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign alu_x_src = r_x_src;
  assign alu_y_src = r_y_src;
  assign alu_op    = r_op;
  assign is_muldiv = r_muldiv;
  assign illegal   = r_illegal;
  assign busy      = !w_cnt_zero;

endmodule

// File: tb/tb_riscv_alu_ctrl_decode_pipe.sv
// Bench for riscv_alu_ctrl_decode_pipe: directed scenarios plus a randomized
// stream scored against a cycle-level reference model of the decoder pipe.
// A second instance with ENABLE_M=0 covers the M-disabled illegal path.
module tb_riscv_alu_ctrl_decode_pipe;

  localparam int MUL_LAT = 3;
  localparam int DIV_LAT = 34;

  typedef struct packed {
    logic [1:0] x;
    logic [1:0] y;
    logic [4:0] op;
    logic       ill;
  } dec_t;

  logic       clk = 1'b0;
  logic       rst, flush, in_valid, out_ready;
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic       in_ready, out_valid, is_muldiv, illegal, busy;
  logic [1:0] alu_x_src, alu_y_src;
  logic [4:0] alu_op;

  logic       m0_flush, m0_in_valid, m0_out_ready;
  logic [6:0] m0_opcode, m0_funct7;
  logic [2:0] m0_funct3;
  logic       m0_in_ready, m0_out_valid, m0_is_muldiv, m0_illegal, m0_busy;
  logic [1:0] m0_alu_x_src, m0_alu_y_src;
  logic [4:0] m0_alu_op;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  riscv_alu_ctrl_decode_pipe #(
    .ALU_OP_WIDTH(5), .ENABLE_M(1), .MUL_LATENCY(MUL_LAT), .DIV_LATENCY(DIV_LAT), .CNT_WIDTH(6)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct3(funct3), .funct7(funct7), .out_valid(out_valid),
    .out_ready(out_ready), .alu_x_src(alu_x_src), .alu_y_src(alu_y_src), .alu_op(alu_op),
    .is_muldiv(is_muldiv), .illegal(illegal), .busy(busy)
  );

  riscv_alu_ctrl_decode_pipe #(
    .ALU_OP_WIDTH(5), .ENABLE_M(0), .MUL_LATENCY(MUL_LAT), .DIV_LATENCY(DIV_LAT), .CNT_WIDTH(6)
  ) dut_nom (
    .clk(clk), .rst(rst), .flush(m0_flush), .in_valid(m0_in_valid), .in_ready(m0_in_ready),
    .opcode(m0_opcode), .funct3(m0_funct3), .funct7(m0_funct7), .out_valid(m0_out_valid),
    .out_ready(m0_out_ready), .alu_x_src(m0_alu_x_src), .alu_y_src(m0_alu_y_src),
    .alu_op(m0_alu_op), .is_muldiv(m0_is_muldiv), .illegal(m0_illegal), .busy(m0_busy)
  );

  // ---------------- reference model ----------------
  function automatic dec_t ref_decode(input logic [6:0] opc, input logic [2:0] f3,
                                      input logic [6:0] f7, input bit m_en);
    int   base_tbl [8] = '{0, 2, 3, 4, 5, 6, 8, 9};
    dec_t d;
    d = '{x: 2'd0, y: 2'd0, op: 5'd31, ill: 1'b0};
    if (opc == 7'h37)                      d = '{x: 2'd2, y: 2'd1, op: 5'd0, ill: 1'b0};
    else if (opc == 7'h17)                 d = '{x: 2'd1, y: 2'd1, op: 5'd0, ill: 1'b0};
    else if (opc == 7'h6F || opc == 7'h67) d = '{x: 2'd1, y: 2'd3, op: 5'd0, ill: 1'b0};
    else if (opc == 7'h63)                 d = '{x: 2'd0, y: 2'd0, op: 5'd1, ill: 1'b0};
    else if (opc == 7'h03 || opc == 7'h23) d = '{x: 2'd0, y: 2'd1, op: 5'd0, ill: 1'b0};
    else if (opc == 7'h13) begin
      d.y  = (f3 == 3'd1 || f3 == 3'd5) ? 2'd2 : 2'd1;
      d.op = 5'(base_tbl[f3]);
      if (f3 == 3'd5 && f7 == 7'h20) d.op = 5'd7;
      if ((f3 == 3'd1 && f7 != 7'h00) || (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20)) d.ill = 1'b1;
    end else if (opc == 7'h33) begin
      if (f7 == 7'h00)                                   d.op = 5'(base_tbl[f3]);
      else if (f7 == 7'h20 && f3 == 3'd0)                d.op = 5'd1;
      else if (f7 == 7'h20 && f3 == 3'd5)                d.op = 5'd7;
      else if (f7 == 7'h01 && m_en)                      d.op = 5'(16 + int'(f3));
      else                                               d.ill = 1'b1;
    end else if (opc == 7'h0F || opc == 7'h73) begin
      d = '{x: 2'd0, y: 2'd0, op: 5'd31, ill: 1'b0};
    end else begin
      d.ill = 1'b1;
    end
    if (d.ill) d = '{x: 2'd0, y: 2'd0, op: 5'd31, ill: 1'b1};
    return d;
  endfunction

  function automatic bit is_multi(input logic [4:0] op);
    return (op >= 16 && op <= 19 && MUL_LAT > 1) || (op >= 20 && op <= 23 && DIV_LAT > 1);
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7);
    in_valid = v;
    opcode   = opc;
    funct3   = f3;
    funct7   = f7;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    flush = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 7'h00, 3'd0, 7'h00);
    step();
    step();
    rst = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    flush = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 7'h00, 3'd0, 7'h00);
    m0_flush = 1'b0; m0_in_valid = 1'b0; m0_out_ready = 1'b1;
    m0_opcode = 7'h00; m0_funct3 = 3'd0; m0_funct7 = 7'h00;
    step();
    step();
    @(negedge clk);
    n_total++;
    if ({out_valid, alu_x_src, alu_y_src, alu_op, is_muldiv, illegal, busy} !== {1'b0, 2'd0, 2'd0, 5'd31, 1'b0, 1'b0, 1'b0})
      $display("FAIL reset_state got v=%0b x=%0d y=%0d op=%0d md=%0b ill=%0b busy=%0b want 0/0/0/31/0/0/0",
               out_valid, alu_x_src, alu_y_src, alu_op, is_muldiv, illegal, busy);
    else n_pass++;
    rst = 1'b0;
    step();
  endtask

  task automatic test_add_sub();
    reset_dut();
    out_ready = 1'b1;
    drive(1'b1, 7'h33, 3'd0, 7'h00);
    @(negedge clk);
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL add_in_ready got %0b want 1", in_ready); else n_pass++;
    step();
    drive(1'b1, 7'h33, 3'd0, 7'h20);
    @(negedge clk);
    n_total++;
    if ({out_valid, alu_x_src, alu_y_src, alu_op, in_ready} !== {1'b1, 2'd0, 2'd0, 5'd0, 1'b1})
      $display("FAIL add_out got v=%0b x=%0d y=%0d op=%0d rdy=%0b want 1/0/0/0/1", out_valid, alu_x_src, alu_y_src, alu_op, in_ready);
    else n_pass++;
    step();
    drive(1'b0, 7'h00, 3'd0, 7'h00);
    @(negedge clk);
    n_total++;
    if ({out_valid, alu_x_src, alu_y_src, alu_op} !== {1'b1, 2'd0, 2'd0, 5'd1})
      $display("FAIL sub_out got v=%0b x=%0d y=%0d op=%0d want 1/0/0/1", out_valid, alu_x_src, alu_y_src, alu_op);
    else n_pass++;
    step();
    @(negedge clk);
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL sub_drain got v=%0b want 0", out_valid); else n_pass++;
    step();
  endtask

  task automatic test_auipc_jal();
    logic [6:0] opcs [3] = '{7'h17, 7'h6F, 7'h13};
    logic [2:0] f3s  [3] = '{3'd0, 3'd0, 3'd5};
    logic [6:0] f7s  [3] = '{7'h00, 7'h00, 7'h20};
    logic [8:0] want [3] = '{{2'd1, 2'd1, 5'd0}, {2'd1, 2'd3, 5'd0}, {2'd0, 2'd2, 5'd7}};
    reset_dut();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, opcs[i], f3s[i], f7s[i]);
      step();
      drive(1'b0, 7'h00, 3'd0, 7'h00);
      @(negedge clk);
      n_total++;
      if ({alu_x_src, alu_y_src, alu_op} !== want[i] || out_valid !== 1'b1)
        $display("FAIL auipc_jal_srai[%0d] got v=%0b x=%0d y=%0d op=%0d want x=%0d y=%0d op=%0d",
                 i, out_valid, alu_x_src, alu_y_src, alu_op, want[i][8:7], want[i][6:5], want[i][4:0]);
      else n_pass++;
      step();
    end
  endtask

  task automatic test_backpressure();
    reset_dut();
    out_ready = 1'b0;
    drive(1'b1, 7'h33, 3'd0, 7'h00);
    step();
    drive(1'b1, 7'h33, 3'd4, 7'h00);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_total++;
      if ({in_ready, out_valid, alu_op} !== {1'b0, 1'b1, 5'd0})
        $display("FAIL bp_hold[%0d] got rdy=%0b v=%0b op=%0d want 0/1/0", i, in_ready, out_valid, alu_op);
      else n_pass++;
      step();
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL bp_release_rdy got %0b want 1", in_ready); else n_pass++;
    step();
    drive(1'b0, 7'h00, 3'd0, 7'h00);
    @(negedge clk);
    n_total++;
    if ({out_valid, alu_op} !== {1'b1, 5'd5})
      $display("FAIL bp_second got v=%0b op=%0d want 1/5", out_valid, alu_op);
    else n_pass++;
    step();
  endtask

  task automatic test_div_stall();
    int busy_cycles;
    reset_dut();
    out_ready = 1'b1;
    drive(1'b1, 7'h33, 3'd4, 7'h01);
    step();
    drive(1'b1, 7'h33, 3'd0, 7'h00);
    @(negedge clk);
    n_total++;
    if ({out_valid, alu_op, is_muldiv, in_ready} !== {1'b1, 5'd20, 1'b1, 1'b0})
      $display("FAIL div_out got v=%0b op=%0d md=%0b rdy=%0b want 1/20/1/0", out_valid, alu_op, is_muldiv, in_ready);
    else n_pass++;
    step();  // DIV handshake happened on this edge
    busy_cycles = 0;
    for (int k = 1; k <= DIV_LAT - 1; k++) begin
      @(negedge clk);
      if (busy === 1'b1 && in_ready === 1'b0) busy_cycles++;
      step();
    end
    n_total++;
    if (busy_cycles != DIV_LAT - 1) $display("FAIL div_busy_cycles got %0d want %0d", busy_cycles, DIV_LAT - 1);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if ({busy, in_ready} !== 2'b01) $display("FAIL div_release got busy=%0b rdy=%0b want 0/1", busy, in_ready);
    else n_pass++;
    step();
    drive(1'b0, 7'h00, 3'd0, 7'h00);
    @(negedge clk);
    n_total++;
    if ({out_valid, alu_op, is_muldiv} !== {1'b1, 5'd0, 1'b0})
      $display("FAIL div_then_add got v=%0b op=%0d md=%0b want 1/0/0", out_valid, alu_op, is_muldiv);
    else n_pass++;
    step();
  endtask

  task automatic test_illegal();
    logic [6:0] opcs [3] = '{7'h7F, 7'h13, 7'h0F};
    logic [2:0] f3s  [3] = '{3'd0, 3'd1, 3'd0};
    logic [6:0] f7s  [3] = '{7'h00, 7'h20, 7'h00};
    logic       want [3] = '{1'b1, 1'b1, 1'b0};
    reset_dut();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, opcs[i], f3s[i], f7s[i]);
      step();
      drive(1'b0, 7'h00, 3'd0, 7'h00);
      @(negedge clk);
      n_total++;
      if ({out_valid, illegal, alu_op, alu_x_src, alu_y_src} !== {1'b1, want[i], 5'd31, 2'd0, 2'd0})
        $display("FAIL illegal[%0d] got v=%0b ill=%0b op=%0d x=%0d y=%0d want 1/%0b/31/0/0",
                 i, out_valid, illegal, alu_op, alu_x_src, alu_y_src, want[i]);
      else n_pass++;
      step();
    end
    // M extension disabled: MUL encoding must come out illegal.
    m0_opcode = 7'h33; m0_funct3 = 3'd0; m0_funct7 = 7'h01; m0_in_valid = 1'b1;
    step();
    m0_in_valid = 1'b0;
    @(negedge clk);
    n_total++;
    if ({m0_out_valid, m0_illegal, m0_alu_op, m0_is_muldiv} !== {1'b1, 1'b1, 5'd31, 1'b0})
      $display("FAIL nom_mul got v=%0b ill=%0b op=%0d md=%0b want 1/1/31/0", m0_out_valid, m0_illegal, m0_alu_op, m0_is_muldiv);
    else n_pass++;
    step();
  endtask

  task automatic test_flush_reset();
    reset_dut();
    out_ready = 1'b1;
    drive(1'b1, 7'h33, 3'd4, 7'h01);
    step();
    drive(1'b0, 7'h00, 3'd0, 7'h00);
    step();  // handshake
    for (int i = 0; i < 4; i++) step();
    flush = 1'b1;
    drive(1'b1, 7'h33, 3'd4, 7'h00);
    @(negedge clk);
    n_total++;
    if ({busy, in_ready} !== 2'b10) $display("FAIL flush_cycle got busy=%0b rdy=%0b want 1/0", busy, in_ready);
    else n_pass++;
    step();
    flush = 1'b0;
    drive(1'b0, 7'h00, 3'd0, 7'h00);
    @(negedge clk);
    n_total++;
    if ({busy, out_valid, in_ready, alu_op} !== {1'b0, 1'b0, 1'b1, 5'd20})
      $display("FAIL flush_after got busy=%0b v=%0b rdy=%0b op=%0d want 0/0/1/20", busy, out_valid, in_ready, alu_op);
    else n_pass++;
    step();
    // flush of a held, back-pressured instruction
    out_ready = 1'b0;
    drive(1'b1, 7'h17, 3'd0, 7'h00);
    step();
    drive(1'b0, 7'h00, 3'd0, 7'h00);
    flush = 1'b1;
    step();
    flush = 1'b0;
    @(negedge clk);
    n_total++;
    if ({out_valid, alu_x_src, alu_op} !== {1'b0, 2'd1, 5'd0})
      $display("FAIL flush_held got v=%0b x=%0d op=%0d want 0/1/0", out_valid, alu_x_src, alu_op);
    else n_pass++;
    // reset during a DIV stall
    out_ready = 1'b1;
    step();
    drive(1'b1, 7'h33, 3'd6, 7'h01);
    step();
    drive(1'b0, 7'h00, 3'd0, 7'h00);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    n_total++;
    if ({busy, in_ready, alu_op, is_muldiv} !== {1'b0, 1'b1, 5'd31, 1'b0})
      $display("FAIL rst_stall got busy=%0b rdy=%0b op=%0d md=%0b want 0/1/31/0", busy, in_ready, alu_op, is_muldiv);
    else n_pass++;
    // reset while holding a valid output
    out_ready = 1'b0;
    drive(1'b1, 7'h17, 3'd0, 7'h00);
    step();
    drive(1'b0, 7'h00, 3'd0, 7'h00);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    n_total++;
    if ({out_valid, alu_x_src, alu_y_src, alu_op, is_muldiv, illegal, busy} !== {1'b0, 2'd0, 2'd0, 5'd31, 1'b0, 1'b0, 1'b0})
      $display("FAIL rst_held got v=%0b x=%0d y=%0d op=%0d md=%0b ill=%0b busy=%0b want 0/0/0/31/0/0/0",
               out_valid, alu_x_src, alu_y_src, alu_op, is_muldiv, illegal, busy);
    else n_pass++;
    step();
  endtask

  task automatic test_random();
    logic [6:0]  opc_tbl [12] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73, 7'h7F};
    bit          m_vld;
    dec_t        m_out, nd;
    int          cyc, stall_until, errs;
    bit          exp_busy, exp_rdy, hs;
    logic [13:0] exp_v, act_v;
    reset_dut();
    m_vld = 1'b0;
    m_out = '{x: 2'd0, y: 2'd0, op: 5'd31, ill: 1'b0};
    cyc = 0;
    stall_until = 0;
    errs = 0;
    for (int i = 0; i < 3000; i++) begin
      int sel;
      logic [6:0] ro, rf7;
      logic [2:0] rf3;
      sel = $urandom_range(0, 12);
      ro  = (sel == 12) ? 7'($urandom) : opc_tbl[sel];
      rf3 = 3'($urandom);
      case ($urandom_range(0, 4))
        0, 1:    rf7 = 7'h00;
        2:       rf7 = 7'h20;
        3:       rf7 = 7'h01;
        default: rf7 = 7'($urandom);
      endcase
      drive(($urandom_range(0, 9) < 6), ro, rf3, rf7);
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 99) < 3);
      @(negedge clk);
      exp_busy = (cyc < stall_until);
      exp_rdy  = !flush && !exp_busy && (!m_vld || (out_ready && !is_multi(m_out.op)));
      exp_v = {m_vld, m_out.x, m_out.y, m_out.op, (m_out.op >= 16 && m_out.op <= 23), m_out.ill, exp_busy, exp_rdy};
      act_v = {out_valid, alu_x_src, alu_y_src, alu_op, is_muldiv, illegal, busy, in_ready};
      n_total++;
      if (act_v !== exp_v) begin
        errs++;
        if (errs <= 10)
          $display("FAIL rand[%0d] got {v,x,y,op,md,ill,busy,rdy}=%b want %b", i, act_v, exp_v);
      end else n_pass++;
      if (flush) begin
        m_vld = 1'b0;
        stall_until = cyc;
      end else begin
        hs = m_vld && out_ready;
        if (hs && m_out.op >= 16 && m_out.op <= 19) stall_until = cyc + MUL_LAT;
        if (hs && m_out.op >= 20 && m_out.op <= 23) stall_until = cyc + DIV_LAT;
        if (in_valid && exp_rdy) begin
          nd = ref_decode(opcode, funct3, funct7, 1'b1);
          m_out = nd;
          m_vld = 1'b1;
        end else if (hs) begin
          m_vld = 1'b0;
        end
      end
      cyc++;
      step();
    end
    flush = 1'b0;
    drive(1'b0, 7'h00, 3'd0, 7'h00);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add_sub();
    test_auipc_jal();
    test_backpressure();
    test_div_stall();
    test_illegal();
    test_flush_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
